// File: rtl/me_topk_collector.sv
// me_topk_collector
//   Top-K minimum-SAD tracker. It collects per-candidate SAD results for one
//   block and keeps the K best sorted ascending. After the block's last
//   candidate it drains them as a ranked list over a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   en_i, sad_valid_i        candidate accepted when both high (COLLECT only)
//   sad_i, row_i, col_i      candidate SAD and position
//   blk_last_i               last candidate of the block (qualified by sad_valid_i)
//   out_valid_o/out_ready_i  ranked-entry handshake
//   out_sad_o/row/col/rank   entry fields; rank 0 is the best
//   out_last_o               final entry of the block
//   busy_o                   high while draining; upstream must hold candidates
//   cand_cnt_o               accepted candidates this block, saturating
//   err_o                    sticky; a candidate arrived during drain and was dropped
module me_topk_collector #(
    parameter int SAD_W    = 14,
    parameter int COORD_W  = 5,
    parameter int K        = 4,
    parameter int TIE_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en_i,
    input  logic                                sad_valid_i,
    input  logic [SAD_W-1:0]                    sad_i,
    input  logic [COORD_W-1:0]                  row_i,
    input  logic [COORD_W-1:0]                  col_i,
    input  logic                                blk_last_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [SAD_W-1:0]                    out_sad_o,
    output logic [COORD_W-1:0]                  out_row_o,
    output logic [COORD_W-1:0]                  out_col_o,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] out_rank_o,
    output logic                                out_last_o,
    output logic                                busy_o,
    output logic [CNT_W-1:0]                    cand_cnt_o,
    output logic                                err_o
);

    localparam int RW = (K > 1) ? $clog2(K) : 1;

    typedef struct packed {
        logic               vld;
        logic [SAD_W-1:0]   sad;
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } ent_t;

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t          state, state_nxt;
    ent_t [K-1:0]    ent, ent_ins;
    ent_t            cand, rd;
    logic [K-1:0]    q;
    logic [K:0]      vld_ext;
    logic [RW-1:0]   ptr;
    logic [CNT_W-1:0] cnt;
    logic            err;
    logic            rd_last, accept, xfer;

    assign cand = '{vld: 1'b1, sad: sad_i, row: row_i, col: col_i};

    // q[i]: candidate would rank ahead of entry i. Since the list is sorted
    // with invalid entries at the tail, q is monotonic; the first set bit is
    // the insertion point.
    for (genvar i = 0; i < K; i++) begin : g_cmp
        if (TIE_MODE != 0) begin : g_late
            assign q[i] = !ent[i].vld || (ent[i].sad >= sad_i);
        end else begin : g_early
            assign q[i] = !ent[i].vld || (ent[i].sad > sad_i);
        end
    end

    // Entries at or after the insertion point shift down by one; the
    // candidate lands at the insertion point; the tail entry falls off.
    always_comb begin
        ent_ins    = ent;
        ent_ins[0] = q[0] ? cand : ent[0];
        for (int i = 1; i < K; i++)
            ent_ins[i] = q[i-1] ? ent[i-1] : (q[i] ? cand : ent[i]);
    end

    // Read side: vld_ext carries a trailing 0 so the top entry is always last.
    always_comb begin
        vld_ext = '0;
        for (int i = 0; i < K; i++) vld_ext[i] = ent[i].vld;
    end

    always_comb begin
        rd      = '0;
        rd_last = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (ptr == RW'(i)) begin
                rd      = ent[i];
                rd_last = !vld_ext[i+1];
            end
        end
    end

    // Outputs are functions of registers only; gated so idle outputs read 0.
    assign out_valid_o = (state == DRAIN) && rd.vld;
    assign out_last_o  = out_valid_o && rd_last;
    assign out_sad_o   = out_valid_o ? rd.sad : '0;
    assign out_row_o   = out_valid_o ? rd.row : '0;
    assign out_col_o   = out_valid_o ? rd.col : '0;
    assign out_rank_o  = out_valid_o ? ptr : '0;
    assign cand_cnt_o  = cnt;
    assign err_o       = err;

    assign accept = (state == COLLECT) && en_i && sad_valid_i;
    assign xfer   = out_valid_o && out_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= COLLECT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        case (state)
            COLLECT: if (accept && blk_last_i) state_nxt = DRAIN;
            DRAIN: begin
                busy_o = 1'b1;
                if (xfer && out_last_o) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent <= '0;
            ptr <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (accept) begin
                ent <= ent_ins;
                if (cnt != '1) cnt <= cnt + CNT_W'(1);
            end
            if ((state == DRAIN) && en_i && sad_valid_i) err <= 1'b1;
            if (xfer) begin
                if (out_last_o) begin
                    for (int i = 0; i < K; i++) ent[i].vld <= 1'b0;
                    ptr <= '0;
                    cnt <= '0;
                end else begin
                    ptr <= ptr + RW'(1);
                end
            end
        end
    end

endmodule

// File: doc/me_topk_collector.md
# me_topk_collector

Parametrised result stage between the motion-estimation core and the top level. It replaces the single-MSAD display path with a top-K minimum-SAD tracker. It accepts a stream of per-candidate SAD results for one current block and keeps the K best candidates sorted ascending. When the block ends, it drains them as a ranked list over a valid/ready handshake.

## Interface
Parameters:
- SAD_W, 14, SAD width in bits.
- COORD_W, 5, row/column coordinate width.
- K, 4, number of best candidates kept (K ≥ 1).
- TIE_MODE, 0, equal-SAD order: 0 = earlier arrival ranks first; 1 = later arrival ranks first.
- CNT_W, 16, candidate counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en_i  in  1  accept enable; when low, inputs are ignored.
- sad_valid_i  in  1  candidate present this cycle.
- sad_i  in  SAD_W  candidate SAD.
- row_i  in  COORD_W  candidate row.
- col_i  in  COORD_W  candidate column.
- blk_last_i  in  1  qualifies sad_valid_i; marks the last candidate of the block.
- out_valid_o  out  1  ranked entry available.
- out_ready_i  in  1  downstream accepts the entry.
- out_sad_o  out  SAD_W  entry SAD.
- out_row_o  out  COORD_W  entry row.
- out_col_o  out  COORD_W  entry column.
- out_rank_o  out  max(1,$clog2(K))  rank; 0 is the best.
- out_last_o  out  1  final entry of the block.
- busy_o  out  1  high in DRAIN; upstream must hold candidates.
- cand_cnt_o  out  CNT_W  candidates accepted in the current block; saturates at all-ones.
- err_o  out  1  sticky; set when a candidate is dropped. Cleared only by reset.

## Operation
- Storage is K entries of {valid, sad, row, col}, kept sorted ascending. Invalid entries compare as greater than any SAD.
- States:
  - COLLECT (reset state): a candidate is accepted when en_i & sad_valid_i.
  - DRAIN: the stored list is emitted.
- Insertion in COLLECT, one cycle:
  - Compute insertion index p. With TIE_MODE=0, p is the first entry whose sad is strictly greater than the candidate. With TIE_MODE=1, p is the first entry whose sad is greater than or equal.
  - Entries p..K-2 shift to p+1..K-1, entry K-1 is discarded, and the candidate is written at p.
  - If no entry qualifies (p = K), the candidate is discarded. This is not an error.
- cand_cnt_o increments on every accepted candidate.
- An accepted candidate with blk_last_i=1 is inserted in that cycle, and the state moves to DRAIN on the next edge.
- Candidates carrying blk_last_i while en_i is low are ignored and do not start DRAIN.
- DRAIN:
  - A read pointer starts at 0. out_valid_o is high while entry[ptr] is valid.
  - out_rank_o = ptr. out_last_o = 1 when ptr = K-1 or entry[ptr+1] is invalid.
  - Each out_valid_o & out_ready_i advances the pointer.
  - The transfer with out_last_o=1 clears all valid bits, clears cand_cnt_o and returns to COLLECT.
- Any sad_valid_i & en_i seen in DRAIN is dropped, sets err_o and leaves the stored list untouched.
- Only the stored entries are emitted: a block with n < K candidates drains n beats.
- SAD arithmetic is unsigned compare only; no saturation or modification of data.

## Timing
- Reset (rst low, asynchronous) clears everything:
  - state = COLLECT.
  - All valid bits = 0.
  - out_valid_o = 0, out_last_o = 0, out_sad_o/row/col/rank = 0.
  - busy_o = 0, cand_cnt_o = 0, err_o = 0.
- Reset asserted mid-DRAIN drops the remaining entries at once; out_valid_o falls asynchronously.
- Insertion latency is 1 cycle: an entry accepted at edge N is visible in the list after edge N.
- The first out_valid_o is driven from registers, in the cycle after the edge that accepted the blk_last_i candidate. busy_o rises in that same cycle.
- Output fields come straight from registers: no combinational path from inputs to outputs.
- While out_valid_o=1 and out_ready_i=0, all out_* fields hold stable.
- Maximum drain rate is one entry per cycle. A block of n ≤ K entries needs n cycles with out_ready_i held high.
- busy_o falls after the out_last_o transfer edge. A candidate may be accepted in the very next cycle.

## Test plan
- **Basic ranking**: K=4, TIE_MODE=0. Candidates (50,r1,c1), (20,r2,c2), (70,..), (20,r4,c4), (10,r5,c5, last); out_ready_i=1.
  - Expect ranks 0–3 = 10(r5), 20(r2), 20(r4), 50(r1); out_last_o on rank 3; 70 is discarded; cand_cnt_o = 5 before the drain ends.
- **Reversed tie order**: same stream with TIE_MODE=1.
  - Expect rank 1 = 20(r4) and rank 2 = 20(r2).
- **Short block**: two candidates, 30 then 12 (last).
  - Expect exactly 2 beats: 12 at rank 0, then 30 at rank 1 with out_last_o=1. Back in COLLECT the following cycle.
- **Backpressure**: hold out_ready_i=0 for 3 cycles during rank 1.
  - Expect out_sad_o, out_row_o, out_col_o, out_rank_o stable and out_valid_o held high; the drain then resumes in order.
- **Input during DRAIN**: sad_valid_i=1, en_i=1, sad_i=0 while busy_o=1.
  - Expect err_o=1 (sticky) and the drained list unchanged. The candidate never appears.
- **Reset mid-drain and single-candidate block**:
  - Assert rst low after rank 0 transfers: expect all outputs 0 immediately and an empty list.
  - Then send a single candidate 5 with last: expect one beat, rank 0, out_last_o=1.
